// File: rtl/mult_pkg.sv
// Shared types and helpers for the time-sliced approximate multiplier.
// Holds the default operand width, the sequencer state encoding and the low-column mask generator.
package mult_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int MASK_MAX  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits below cols set; callers cast down to their product width.
    function automatic logic [MASK_MAX-1:0] lowmask(input int cols);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < cols) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/pp_accum_seq_if.sv
// Operand and product handshakes of the partial-product sequencer.
// The sequencer uses the slave view; the operand source and product consumer use the master view.
interface pp_accum_seq_if #(
    parameter int WIDTH = mult_pkg::DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_x;
    logic [WIDTH-1:0]   in_y;
    logic               in_approx;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               out_approx;

    modport master (
        output in_valid, in_x, in_y, in_approx, out_ready,
        input  in_ready, out_valid, out_p, out_approx
    );

    modport slave (
        input  in_valid, in_x, in_y, in_approx, out_ready,
        output in_ready, out_valid, out_p, out_approx
    );
endinterface

// File: rtl/pp_row_slice.sv
// Combinational slice of the partial-product array: produces ROWS_PER_CYCLE rows
// starting at row_idx, each already shifted to its weight within the 2W-bit product.
module pp_row_slice
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic [WIDTH-1:0]                             x,
    input  logic [WIDTH-1:0]                             y,
    input  logic [$clog2(WIDTH)-1:0]                     row_idx,
    output logic [ROWS_PER_CYCLE-1:0][2*WIDTH-1:0]       rows
);
    localparam int IW = $clog2(WIDTH);

    logic [IW-1:0] idx_s;

    // Row k of the slice is y gated by x[row_idx+k], placed at weight 2^(row_idx+k).
    always_comb begin
        rows  = '0;
        idx_s = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            idx_s   = row_idx + IW'(k);
            rows[k] = {{WIDTH{1'b0}}, (y & {WIDTH{x[idx_s]}})} << idx_s;
        end
    end

endmodule

// File: rtl/pp_accum_seq.sv
// Multi-cycle partial-product sequencer: accepts an operand pair, reduces ROWS_PER_CYCLE
// rows per clock into the product accumulator, and returns the product over a handshake.
module pp_accum_seq
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int ROWS_PER_CYCLE = 4,
    parameter int APPROX_COLS    = 8
) (
    input  logic           clk,
    input  logic           rst,
    pp_accum_seq_if.slave  bus,
    output logic           busy
);
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);
    localparam logic [PW-1:0] LOWMASK  = PW'(lowmask(APPROX_COLS));
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - ROWS_PER_CYCLE);
    localparam logic [IW-1:0] IDX_STEP = IW'(ROWS_PER_CYCLE);

    state_e                             state_q;
    logic [WIDTH-1:0]                   x_q;
    logic [WIDTH-1:0]                   y_q;
    logic                               approx_q;
    logic [IW-1:0]                      row_idx_q;
    logic [PW-1:0]                      acc_hi_q;
    logic [PW-1:0]                      acc_lo_q;
    logic [PW-1:0]                      out_p_q;
    logic                               out_approx_q;
    logic                               out_valid_q;
    logic                               busy_q;

    logic [ROWS_PER_CYCLE-1:0][PW-1:0]  rows_s;
    logic [PW-1:0]                      eff_mask_s;
    logic [PW-1:0]                      hi_sum_s;
    logic [PW-1:0]                      lo_or_s;
    logic [PW-1:0]                      acc_hi_d;
    logic [PW-1:0]                      acc_lo_d;
    logic [PW-1:0]                      prod_d;

    pp_row_slice #(
        .WIDTH          (WIDTH),
        .ROWS_PER_CYCLE (ROWS_PER_CYCLE)
    ) u_slice (
        .x       (x_q),
        .y       (y_q),
        .row_idx (row_idx_q),
        .rows    (rows_s)
    );

    // Exact mode uses an empty mask, so acc_lo stays zero and acc_hi is the full sum.
    always_comb begin
        eff_mask_s = approx_q ? LOWMASK : {PW{1'b0}};
        hi_sum_s   = '0;
        lo_or_s    = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            hi_sum_s = hi_sum_s + (rows_s[k] & ~eff_mask_s);
            lo_or_s  = lo_or_s | (rows_s[k] & eff_mask_s);
        end
        acc_hi_d = acc_hi_q + hi_sum_s;
        acc_lo_d = acc_lo_q | lo_or_s;
        prod_d   = (acc_hi_d & ~eff_mask_s) | acc_lo_d;
    end

    // Sequencer FSM with accumulators and registered product outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            approx_q     <= 1'b0;
            row_idx_q    <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            out_p_q      <= '0;
            out_approx_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q       <= bus.in_x;
                        y_q       <= bus.in_y;
                        approx_q  <= bus.in_approx;
                        row_idx_q <= '0;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ACCUM;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                ACCUM: begin
                    acc_hi_q  <= acc_hi_d;
                    acc_lo_q  <= acc_lo_d;
                    row_idx_q <= row_idx_q + IDX_STEP;
                    if (row_idx_q == LAST_IDX) begin
                        out_p_q      <= prod_d;
                        out_approx_q <= approx_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        state_q      <= ACCUM;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst so it reads low throughout reset and high right after release.
    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_p      = out_p_q;
    assign bus.out_approx = out_approx_q;
    assign busy           = busy_q;

endmodule
